// File: rtl/rdma_pkg.sv
// rdma_pkg: shared CQE layout, completion status codes and IRQ coalescing states.
package rdma_pkg;
  localparam int CQE_W = 32;
  localparam int CQE_SEQ_LSB = 0;
  localparam int CQE_STAT_LSB = 24;
  localparam logic [3:0] CQ_ST_OK = 4'h0;
  localparam logic [3:0] CQ_ST_ERR = 4'h1;
  localparam logic [3:0] CQ_ST_FLUSH = 4'h2;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_ARMED, IRQ_FIRED} irq_state_e;
  function automatic logic [CQE_W-1:0] make_cqe(input logic [3:0] st, input logic [CQE_STAT_LSB-1:0] seq);
    return (CQE_W'(st) << CQE_STAT_LSB) | (CQE_W'(seq) << CQE_SEQ_LSB);
  endfunction
endpackage

// File: rtl/rdma_cq_fifo.sv
// rdma_cq_fifo: first-word fall-through sync FIFO with occupancy count; push+pop at full is legal.
module rdma_cq_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign full = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign count = r_count;
  assign dout = r_mem[r_rd];
  // A pop frees the head slot this cycle, so a push at full can reuse it.
  assign w_pop = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/rdma_cq_engine.sv
// rdma_cq_engine: sequences completions into a CQE ring, counts overflow drops,
// and coalesces host interrupts by threshold or timeout.
module rdma_cq_engine
  import rdma_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int COAL_THRESH = 4,
  parameter int COAL_TIMEOUT = 256,
  parameter int SEQ_W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   comp_valid,
  input  logic [3:0]             comp_status,
  output logic                   cqe_valid,
  input  logic                   cqe_ready,
  output logic [CQE_W-1:0]       cqe_data,
  output logic [$clog2(DEPTH):0] cq_count,
  output logic                   irq,
  input  logic                   irq_ack,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic [15:0]            drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(COAL_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(COAL_TIMEOUT - 1);
  logic [SEQ_W-1:0] r_seq;
  logic [15:0] r_drop_cnt;
  logic r_ovf, r_irq;
  logic [TW-1:0] r_timer;
  irq_state_e r_state;
  logic w_full, w_empty, w_pop, w_drop, w_nz;
  logic [CQE_W-1:0] w_dout;
  assign w_pop = ~w_empty & cqe_ready;
  assign w_drop = comp_valid & w_full & ~w_pop;
  assign w_nz = cq_count != '0;
  rdma_cq_fifo #(.DEPTH(DEPTH), .W(CQE_W)) u_fifo (
    .clk(clk), .rst(rst), .push(comp_valid), .pop(cqe_ready),
    .din(make_cqe(comp_status, CQE_STAT_LSB'(r_seq))), .dout(w_dout),
    .full(w_full), .empty(w_empty), .count(cq_count)
  );
  assign cqe_valid = ~w_empty;
  assign cqe_data = w_empty ? '0 : w_dout;
  assign irq = r_irq;
  assign ovf = r_ovf;
  assign drop_cnt = r_drop_cnt;
  // Sequence advances on dropped completions too, so the host can see gaps.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_seq <= '0;
      r_drop_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (comp_valid) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      r_ovf <= w_drop ? 1'b1 : ovf_clr ? 1'b0 : r_ovf;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IRQ_IDLE;
      r_timer <= '0;
      r_irq <= 1'b0;
    end else begin
      case (r_state)
        IRQ_IDLE:
          if (w_nz) begin
            r_state <= IRQ_ARMED;
            r_timer <= '0;
          end
        IRQ_ARMED:
          if (!w_nz) r_state <= IRQ_IDLE;
          else if (cq_count >= CW'(COAL_THRESH) || r_timer == TMAX) begin
            r_state <= IRQ_FIRED;
            r_irq <= 1'b1;
          end else r_timer <= r_timer + TW'(1);
        IRQ_FIRED:
          if (irq_ack) begin
            r_state <= w_nz ? IRQ_ARMED : IRQ_IDLE;
            r_timer <= '0;
            r_irq <= 1'b0;
          end
        default: begin
          r_state <= IRQ_IDLE;
          r_irq <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_rdma_cq_engine.sv
// tb_rdma_cq_engine: directed and randomized checks of the CQ engine against a queue-based model.
module tb_rdma_cq_engine;
  logic clk = 1'b0;
  logic rst, comp_valid, cqe_ready, irq_ack, ovf_clr;
  logic [3:0] comp_status;
  logic cqe_valid, irq, ovf;
  logic [31:0] cqe_data;
  logic [4:0] cq_count;
  logic [15:0] drop_cnt;
  int n_chk = 0, n_pass = 0;
  logic [31:0] q[$];
  int m_seq = 0, m_drop = 0;
  bit m_ovf = 0;
  bit seen;
  rdma_cq_engine dut (
    .clk(clk), .rst(rst), .comp_valid(comp_valid), .comp_status(comp_status),
    .cqe_valid(cqe_valid), .cqe_ready(cqe_ready), .cqe_data(cqe_data), .cq_count(cq_count),
    .irq(irq), .irq_ack(irq_ack), .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic mchk(input string tag);
    chk({tag, ".valid"}, 32'(cqe_valid), 32'(q.size() != 0));
    chk({tag, ".count"}, 32'(cq_count), 32'(q.size()));
    chk({tag, ".data"}, cqe_data, q.size() != 0 ? q[0] : 32'h0);
    chk({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
  endtask
  task automatic cyc(input bit cv, input bit [3:0] st, input bit rdy, input bit ack, input bit clr);
    bit pop, drop;
    logic [23:0] s;
    comp_valid = cv; comp_status = st; cqe_ready = rdy; irq_ack = ack; ovf_clr = clr;
    pop = q.size() > 0 && rdy;
    drop = cv && q.size() == 16 && !pop;
    s = 24'(m_seq);
    if (pop) void'(q.pop_front());
    if (cv && !drop) q.push_back({4'h0, st, s});
    if (cv) m_seq++;
    if (drop && m_drop < 65535) m_drop++;
    m_ovf = drop ? 1'b1 : clr ? 1'b0 : m_ovf;
    @(posedge clk); #1;
    comp_valid = 0; cqe_ready = 0; irq_ack = 0; ovf_clr = 0;
  endtask
  task automatic push(input bit [3:0] st); cyc(1, st, 0, 0, 0); endtask
  task automatic idle(); cyc(0, 4'h0, 0, 0, 0); endtask
  task automatic pop1(); cyc(0, 4'h0, 1, 0, 0); endtask
  task automatic ack(); cyc(0, 4'h0, 0, 1, 0); endtask
  task automatic zero_chk(input string tag);
    chk({tag, ".valid"}, 32'(cqe_valid), 0);
    chk({tag, ".data"}, cqe_data, 0);
    chk({tag, ".count"}, 32'(cq_count), 0);
    chk({tag, ".irq"}, 32'(irq), 0);
    chk({tag, ".ovf"}, 32'(ovf), 0);
    chk({tag, ".drop"}, 32'(drop_cnt), 0);
  endtask
  task automatic do_reset(input string tag);
    rst = 1; #1;
    zero_chk(tag);
    @(posedge clk); #1;
    rst = 0;
    q.delete(); m_seq = 0; m_drop = 0; m_ovf = 0;
  endtask
  initial begin
    comp_valid = 0; comp_status = 0; cqe_ready = 0; irq_ack = 0; ovf_clr = 0;
    do_reset("reset0");
    push(4'h1);
    chk("first.valid", 32'(cqe_valid), 1);
    chk("first.data", cqe_data, 32'h0100_0000);
    chk("first.count", 32'(cq_count), 1);
    chk("first.irq", 32'(irq), 0);
    pop1();
    mchk("first_pop");
    repeat (3) idle();
    for (int i = 0; i < 4; i++) push(4'($urandom));
    mchk("burst4");
    chk("burst4.irq_pre", 32'(irq), 0);
    idle();
    chk("burst4.irq", 32'(irq), 1);
    ack();
    chk("ack4.irq", 32'(irq), 0);
    chk("ack4.count", 32'(cq_count), 4);
    idle();
    chk("refire.irq", 32'(irq), 1);
    for (int i = 0; i < 4; i++) begin
      pop1();
      mchk("drain4");
    end
    chk("drain4.irq_held", 32'(irq), 1);
    ack();
    chk("drain4.ack", 32'(irq), 0);
    repeat (2) idle();
    chk("idle.irq", 32'(irq), 0);
    push(4'h2);
    repeat (256) idle();
    chk("tmo.before", 32'(irq), 0);
    idle();
    chk("tmo.fire", 32'(irq), 1);
    pop1();
    ack();
    chk("tmo.ack", 32'(irq), 0);
    push(4'h0);
    repeat (100) idle();
    pop1();
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      idle();
      if (irq) seen = 1;
    end
    chk("polled.no_irq", 32'(seen), 0);
    do_reset("reset1");
    for (int i = 0; i < 18; i++) push(4'($urandom));
    mchk("ovf18");
    chk("ovf18.count", 32'(cq_count), 16);
    chk("ovf18.drop", 32'(drop_cnt), 2);
    chk("ovf18.ovf", 32'(ovf), 1);
    chk("ovf18.head_seq", 32'(cqe_data[23:0]), 0);
    cyc(1, 4'h2, 1, 0, 0);
    mchk("full_pushpop");
    chk("full_pushpop.count", 32'(cq_count), 16);
    chk("full_pushpop.drop", 32'(drop_cnt), 2);
    cyc(1, 4'h1, 0, 0, 1);
    chk("clr_vs_drop.ovf", 32'(ovf), 1);
    chk("clr_vs_drop.drop", 32'(drop_cnt), 3);
    cyc(0, 4'h0, 0, 0, 1);
    chk("clr.ovf", 32'(ovf), 0);
    for (int k = 0; k < 16; k++) begin
      chk("drain16.seq", 32'(cqe_data[23:0]), k < 15 ? k + 1 : 18);
      pop1();
      mchk("drain16");
    end
    for (int i = 0; i < 7; i++) push(4'($urandom));
    chk("mid.count", 32'(cq_count), 7);
    chk("mid.irq", 32'(irq), 1);
    chk("mid.drop", 32'(drop_cnt), 3);
    comp_valid = 1;
    do_reset("midreset");
    comp_valid = 0;
    push(4'h0);
    chk("post_reset.seq", 32'(cqe_data[23:0]), 0);
    mchk("post_reset");
    do_reset("reset2");
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 9) < 6, 4'($urandom), $urandom_range(0, 9) < 4,
          $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      mchk("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
